rf_multiport: RTL and testbench

Parametrised general-purpose register file for the MIPS-style datapath: one synchronous write port, two combinational read ports with same-cycle write-to-read bypass, optional hard-wired zero register, and a post-reset hardware clear sequencer. An optional per-register pending-write scoreboard lets decode stall on multi-cycle writebacks. It replaces the fixed 32x32 register file in the decode stage.

---
 rtl/rf_multiport.sv | 152 +++++++++++++++
 tb/tb_rf_multiport.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/rf_multiport.sv
// Multiport register file: one synchronous write port, two combinational read ports with
// write bypass, optional zero register and post-reset clear. Scoreboard gated by RF_SCOREBOARD_EN.
module rf_multiport #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr1,
  output logic [DATA_W-1:0] rd_data1,
  input  logic [ADDR_W-1:0] rd_addr2,
  output logic [DATA_W-1:0] rd_data2,
  output logic              ready,
  input  logic              busy_set,
  input  logic [ADDR_W-1:0] busy_addr,
  output logic              rd_busy1,
  output logic              rd_busy2
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam bit ZR    = (ZERO_REG != 0);

  typedef enum logic {CLEAR, RUN} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] clr_ptr_q, clr_ptr_d;

  logic              rf_we;
  logic [ADDR_W-1:0] rf_waddr;
  logic [DATA_W-1:0] rf_wdata;
  logic [DATA_W-1:0] rf_mem [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= CLEAR;
      clr_ptr_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_ptr_q <= clr_ptr_d;
    end
  end

  // The clear sequencer owns the write port until the last register is zeroed.
  always_comb begin
    state_d   = state_q;
    clr_ptr_d = clr_ptr_q;
    rf_we     = 1'b0;
    rf_waddr  = wr_addr;
    rf_wdata  = wr_data;
    case (state_q)
      CLEAR: begin
        rf_we     = 1'b1;
        rf_waddr  = clr_ptr_q;
        rf_wdata  = '0;
        clr_ptr_d = clr_ptr_q + 1'b1;
        if (clr_ptr_q == {ADDR_W{1'b1}}) begin
          state_d   = RUN;
          clr_ptr_d = '0;
        end
      end
      RUN: begin
        rf_we = wr_en && !(ZR && (wr_addr == '0));
      end
      default: begin
        state_d = CLEAR;
      end
    endcase
  end

  assign ready = (state_q == RUN);

  always_ff @(posedge clk) begin
    if (rf_we) begin
      rf_mem[rf_waddr] <= rf_wdata;
    end
  end

`ifdef RF_SCOREBOARD_EN
  logic [DEPTH-1:0] busy_q, busy_d;

  // Set is applied after clear so a same-address set/clear leaves the register busy.
  always_comb begin
    busy_d = busy_q;
    if (state_q == RUN) begin
      if (wr_en) begin
        busy_d[wr_addr] = 1'b0;
      end
      if (busy_set) begin
        busy_d[busy_addr] = 1'b1;
      end
    end
    if (ZR) begin
      busy_d[0] = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end
`else
  logic unused_scoreboard_inputs;
  assign unused_scoreboard_inputs = ^{busy_set, busy_addr};
`endif

  logic [ADDR_W-1:0] rd_addr_a [2];
  logic [DATA_W-1:0] rd_data_a [2];
  logic              rd_busy_a [2];

  assign rd_addr_a[0] = rd_addr1;
  assign rd_addr_a[1] = rd_addr2;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_rd_port
      logic zero_hit;
      logic wr_hit;
      assign zero_hit = ZR && (rd_addr_a[gi] == '0);
      assign wr_hit   = wr_en && (wr_addr == rd_addr_a[gi]);

      always_comb begin
        rd_data_a[gi] = '0;
        if (ready) begin
          if (wr_hit && !zero_hit) begin
            rd_data_a[gi] = wr_data;
          end else if (!zero_hit) begin
            rd_data_a[gi] = rf_mem[rd_addr_a[gi]];
          end
        end
      end

`ifdef RF_SCOREBOARD_EN
      // A write landing this cycle already counts as complete, matching the bypass.
      assign rd_busy_a[gi] = ready && busy_q[rd_addr_a[gi]] && !wr_hit;
`else
      assign rd_busy_a[gi] = 1'b0;
`endif
    end
  endgenerate

  assign rd_data1 = rd_data_a[0];
  assign rd_data2 = rd_data_a[1];
  assign rd_busy1 = rd_busy_a[0];
  assign rd_busy2 = rd_busy_a[1];

endmodule

// File: tb/tb_rf_multiport.sv
// Directed bench for rf_multiport: two instances (ZERO_REG=1 and ZERO_REG=0) share stimulus;
// expected values are queued as each step is driven and popped when outputs are sampled.
module tb_rf_multiport;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int DEPTH = 32;
`ifdef RF_SCOREBOARD_EN
  localparam bit SB = 1'b1;
`else
  localparam bit SB = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic [AW-1:0] rd_addr1, rd_addr2;
  logic          busy_set;
  logic [AW-1:0] busy_addr;

  logic [DW-1:0] a_rd_data1, a_rd_data2, b_rd_data1, b_rd_data2;
  logic          a_ready, b_ready;
  logic          a_rd_busy1, a_rd_busy2, b_rd_busy1, b_rd_busy2;

  int errors = 0;
  int checks = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  rf_multiport #(.DATA_W(DW), .ADDR_W(AW), .ZERO_REG(1)) u_zr1 (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr1(rd_addr1), .rd_data1(a_rd_data1), .rd_addr2(rd_addr2), .rd_data2(a_rd_data2),
    .ready(a_ready), .busy_set(busy_set), .busy_addr(busy_addr),
    .rd_busy1(a_rd_busy1), .rd_busy2(a_rd_busy2)
  );

  rf_multiport #(.DATA_W(DW), .ADDR_W(AW), .ZERO_REG(0)) u_zr0 (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr1(rd_addr1), .rd_data1(b_rd_data1), .rd_addr2(rd_addr2), .rd_data2(b_rd_data2),
    .ready(b_ready), .busy_set(busy_set), .busy_addr(busy_addr),
    .rd_busy1(b_rd_busy1), .rd_busy2(b_rd_busy2)
  );

  task automatic exp(input logic [31:0] v);
    exp_q.push_back(v);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs);
    logic [31:0] e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s observed=%h expected=<none queued>", tag, obs);
    end else begin
      e = exp_q.pop_front();
      assert (obs === e) else begin
        errors++;
        $error("FAIL %s observed=%h expected=%h", tag, obs, e);
      end
    end
  endtask

  // Inputs change on the falling edge; outputs are sampled 2 time units later.
  task automatic drive(input logic we, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                       input logic [AW-1:0] a1, input logic [AW-1:0] a2,
                       input logic bs, input logic [AW-1:0] ba);
    @(negedge clk);
    wr_en = we; wr_addr = wa; wr_data = wd;
    rd_addr1 = a1; rd_addr2 = a2;
    busy_set = bs; busy_addr = ba;
    #2;
  endtask

  task automatic release_and_count(input string tag);
    int first_a, first_b;
    first_a = 0;
    first_b = 0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int e = 1; e <= DEPTH + 8; e++) begin
      @(posedge clk);
      #1;
      if (a_ready === 1'b1 && first_a == 0) first_a = e;
      if (b_ready === 1'b1 && first_b == 0) first_b = e;
    end
    exp(DEPTH);
    exp(DEPTH);
    chk({tag, "_zr1"}, first_a);
    chk({tag, "_zr0"}, first_b);
  endtask

  initial begin
    rst_n = 1'b1;
    wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    rd_addr1 = '0; rd_addr2 = '0; busy_set = 1'b0; busy_addr = '0;
    #1;
    rst_n = 1'b0;

    drive(0, 0, 0, 3, 9, 0, 0);
    exp(0); exp(0); exp(0); exp(0); exp(0);
    chk("rst_ready_zr1", a_ready);
    chk("rst_ready_zr0", b_ready);
    chk("rst_rd1", a_rd_data1);
    chk("rst_rd2", a_rd_data2);
    chk("rst_busy1", a_rd_busy1);

    release_and_count("ready_edges");

    for (int i = 0; i < DEPTH; i++) begin
      drive(0, 0, 0, AW'(i), AW'(DEPTH - 1 - i), 0, 0);
      exp(0); exp(0); exp(0);
      chk("clear_rd1_zr1", a_rd_data1);
      chk("clear_rd2_zr1", a_rd_data2);
      chk("clear_rd1_zr0", b_rd_data1);
    end

    drive(1, 7, 32'hDEADBEEF, 7, 7, 0, 0);
    exp(32'hDEADBEEF); exp(32'hDEADBEEF);
    chk("bypass_r7_rd1", a_rd_data1);
    chk("bypass_r7_rd2", a_rd_data2);
    drive(0, 0, 0, 7, 3, 0, 0);
    exp(32'hDEADBEEF); exp(0);
    chk("stored_r7", a_rd_data1);
    chk("untouched_r3", a_rd_data2);

    drive(1, 0, 32'h12345678, 0, 0, 0, 0);
    exp(0); exp(0); exp(32'h12345678); exp(32'h12345678);
    chk("r0_bypass_rd1_zr1", a_rd_data1);
    chk("r0_bypass_rd2_zr1", a_rd_data2);
    chk("r0_bypass_rd1_zr0", b_rd_data1);
    chk("r0_bypass_rd2_zr0", b_rd_data2);
    drive(0, 0, 0, 0, 0, 0, 0);
    exp(0); exp(32'h12345678);
    chk("r0_stored_zr1", a_rd_data1);
    chk("r0_stored_zr0", b_rd_data2);

    drive(1, 5, 32'hAAAA5555, 6, 5, 0, 0);
    exp(0); exp(32'hAAAA5555);
    chk("nobypass_r6", a_rd_data1);
    chk("bypass_r5_rd2", a_rd_data2);
    drive(0, 0, 0, 5, 7, 0, 0);
    exp(32'hAAAA5555); exp(32'hDEADBEEF);
    chk("stored_r5", a_rd_data1);
    chk("stored_r7_again", a_rd_data2);

    drive(0, 0, 0, 9, 9, 1, 9);
    exp(0);
    chk("busy_set_same_cycle", a_rd_busy1);
    drive(0, 0, 0, 9, 9, 0, 0);
    exp(SB); exp(SB);
    chk("busy_next_rd1", a_rd_busy1);
    chk("busy_next_rd2", a_rd_busy2);
    drive(1, 9, 32'h00000099, 9, 9, 0, 0);
    exp(0); exp(0); exp(32'h00000099);
    chk("busy_wr_same_cycle_rd1", a_rd_busy1);
    chk("busy_wr_same_cycle_rd2", a_rd_busy2);
    chk("busy_wr_bypass", a_rd_data1);
    drive(0, 0, 0, 9, 9, 0, 0);
    exp(0);
    chk("busy_cleared", a_rd_busy1);
    drive(1, 9, 32'h0000009A, 9, 9, 1, 9);
    exp(0);
    chk("set_and_wr_same_cycle", a_rd_busy1);
    drive(0, 0, 0, 9, 4, 0, 0);
    exp(SB); exp(0);
    chk("set_wins", a_rd_busy1);
    chk("r4_not_busy", a_rd_busy2);
    drive(0, 0, 0, 4, 4, 1, 4);
    drive(0, 0, 0, 4, 4, 0, 0);
    exp(SB); exp(SB);
    chk("busy_r4_rd1", a_rd_busy1);
    chk("busy_r4_rd2", a_rd_busy2);

    drive(0, 0, 0, 0, 0, 1, 0);
    drive(0, 0, 0, 0, 0, 0, 0);
    exp(0); exp(SB);
    chk("r0_busy_zr1", a_rd_busy1);
    chk("r0_busy_zr0", b_rd_busy1);

    drive(1, 3, 32'h00000005, 3, 9, 0, 0);
    drive(0, 0, 0, 3, 9, 0, 0);
    exp(32'h00000005); exp(SB);
    chk("r3_before_reset", a_rd_data1);
    chk("r9_busy_before_reset", a_rd_busy2);
    @(negedge clk);
    rst_n = 1'b0;
    #2;
    exp(0); exp(0); exp(0); exp(0);
    chk("midrun_rst_ready", a_ready);
    chk("midrun_rst_rd1", a_rd_data1);
    chk("midrun_rst_busy2", a_rd_busy2);
    chk("midrun_rst_busy_zr0", b_rd_busy2);

    release_and_count("ready_edges_again");
    drive(0, 0, 0, 3, 9, 0, 0);
    exp(0); exp(0); exp(0); exp(0);
    chk("r3_cleared", a_rd_data1);
    chk("r9_cleared", a_rd_data2);
    chk("r9_not_busy", a_rd_busy2);
    chk("r9_not_busy_zr0", b_rd_busy2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
